// File: rtl/fetch_decode_reg_pkg.sv
// Shared fetch/decode constants: address and instruction widths, the NOP
// encoding shown to decode when nothing valid is in ID, and the PC types.
package fetch_decode_reg_pkg;

  localparam int ADDR_W  = 14;
  localparam int INSTR_W = 16;

  // Bubble encoding presented on id_instr whenever id_valid is low
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  // Width of the PC+1 adder; the return address wraps modulo 2^PC_INC_W
  localparam int PC_INC_W = ADDR_W;

  typedef logic [ADDR_W-1:0]  pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

endpackage

// File: rtl/fetch_decode_reg_hold.sv
// One-entry hold buffer for the IF/ID register. Program memory only drives
// valid data in the cycle after an enabled read, so when a stall starts the
// returning word is parked here and replayed when the pipeline advances.
module instr_hold_buffer #(
  parameter int                  INSTR_W   = fetch_decode_reg_pkg::INSTR_W,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = fetch_decode_reg_pkg::NOP_INSTR
) (
  input  logic               clock,
  input  logic               nreset,
  input  logic               flush_i,
  input  logic               stall_i,
  input  logic               req_valid_i,
  input  logic [INSTR_W-1:0] rdata_i,
  output logic               hold_valid_o,
  output logic [INSTR_W-1:0] src_instr_o
);

  logic               hold_valid_q, hold_valid_d;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;

  // Capture once at the start of a stall; flush or advance empties the buffer
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    if (flush_i || !stall_i) begin
      hold_valid_d = 1'b0;
    end else if (req_valid_i && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_instr_d = rdata_i;
    end
  end

  // Buffer state register
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      hold_valid_q <= 1'b0;
      hold_instr_q <= NOP_INSTR;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  // Held word takes precedence over whatever memory is driving now
  assign src_instr_o  = hold_valid_q ? hold_instr_q : rdata_i;
  assign hold_valid_o = hold_valid_q;

endmodule

// File: rtl/fetch_decode_reg.sv
// IF/ID pipeline register. Pairs each synchronous program-memory word with
// the PC that fetched it and presents instruction, PC and PC+1 to decode.
// Per-edge priority: flush > stall > advance.
module fetch_decode_reg #(
  parameter int                 ADDR_W    = fetch_decode_reg_pkg::ADDR_W,
  parameter int                 INSTR_W   = fetch_decode_reg_pkg::INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = fetch_decode_reg_pkg::NOP_INSTR
) (
  input  logic               clock,
  input  logic               nreset,
  input  logic               stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  fetch_addr,
  input  logic [INSTR_W-1:0] prog_mem_rdata,
  output logic               prog_mem_rd_en,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_next_pc
);

  // Read issued last cycle; its data is on prog_mem_rdata this cycle
  logic               req_valid_q, req_valid_d;
  logic [ADDR_W-1:0]  req_pc_q,    req_pc_d;

  logic               id_valid_q,  id_valid_d;
  logic [INSTR_W-1:0] id_instr_q,  id_instr_d;
  logic [ADDR_W-1:0]  id_pc_q,     id_pc_d;
  logic [ADDR_W-1:0]  id_next_q,   id_next_d;

  logic               hold_valid;
  logic [INSTR_W-1:0] src_instr;

  instr_hold_buffer #(
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_hold (
    .clock        (clock),
    .nreset       (nreset),
    .flush_i      (flush),
    .stall_i      (stall),
    .req_valid_i  (req_valid_q),
    .rdata_i      (prog_mem_rdata),
    .hold_valid_o (hold_valid),
    .src_instr_o  (src_instr)
  );

  // Next-state for request tracking and ID registers under flush/stall/advance
  always_comb begin
    req_valid_d = req_valid_q;
    req_pc_d    = req_pc_q;
    id_valid_d  = id_valid_q;
    id_instr_d  = id_instr_q;
    id_pc_d     = id_pc_q;
    id_next_d   = id_next_q;
    if (flush) begin
      // Wrong-path read in flight is dropped; id_pc/id_next_pc keep their values
      req_valid_d = 1'b0;
      id_valid_d  = 1'b0;
      id_instr_d  = NOP_INSTR;
    end else if (!stall) begin
      id_valid_d  = req_valid_q;
      id_instr_d  = req_valid_q ? src_instr : NOP_INSTR;
      id_pc_d     = req_pc_q;
      id_next_d   = req_pc_q + ADDR_W'(1);
      req_valid_d = 1'b1;
      req_pc_d    = fetch_addr;
    end
  end

  // State registers; reset discards everything immediately
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
      id_valid_q  <= 1'b0;
      id_instr_q  <= NOP_INSTR;
      id_pc_q     <= '0;
      id_next_q   <= ADDR_W'(1);
    end else begin
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
      id_valid_q  <= id_valid_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
      id_next_q   <= id_next_d;
    end
  end

  // A stalled fetch must not consume a read slot
  assign prog_mem_rd_en = !stall;
  assign id_valid       = id_valid_q;
  assign id_instr       = id_instr_q;
  assign id_pc          = id_pc_q;
  assign id_next_pc     = id_next_q;

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Bench for fetch_decode_reg: directed scenarios followed by randomized
// flush/stall traffic, checked against a transaction-level model.
module tb_fetch_decode_reg;
  import fetch_decode_reg_pkg::*;

  // ---------------- clock / reset ----------------
  logic         clock = 1'b0;
  logic         nreset;
  logic         stall, flush;
  logic [13:0]  fetch_addr;
  logic [15:0]  prog_mem_rdata;
  logic         prog_mem_rd_en;
  logic         id_valid;
  logic [15:0]  id_instr;
  logic [13:0]  id_pc, id_next_pc;

  always #5 clock = ~clock;

  fetch_decode_reg dut (
    .clock          (clock),
    .nreset         (nreset),
    .stall          (stall),
    .flush          (flush),
    .fetch_addr     (fetch_addr),
    .prog_mem_rdata (prog_mem_rdata),
    .prog_mem_rd_en (prog_mem_rd_en),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_next_pc     (id_next_pc)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Memory contents as seen by the bench
  function automatic logic [15:0] word(input logic [13:0] a);
    return 16'hA000 + {2'b00, a};
  endfunction

  // Reference model: a queue of fetched-but-not-yet-decoded words (at most
  // one entry) plus the expected ID view.
  logic [15:0] exp_q[$];
  logic        exp_valid;
  logic [15:0] exp_instr;
  logic [13:0] exp_pc, exp_next;
  logic [13:0] last_issued;

  logic        prev_rd;
  logic [13:0] prev_addr;
  logic [15:0] garbage;

  task automatic model_reset();
    exp_q.delete();
    exp_valid   = 1'b0;
    exp_instr   = NOP_INSTR;
    exp_pc      = 14'd0;
    exp_next    = 14'd1;
    last_issued = 14'd0;
    prev_rd     = 1'b0;
    prev_addr   = 14'd0;
  endtask

  task automatic model_edge(input logic f, input logic s, input logic [13:0] a);
    if (f) begin
      exp_q.delete();
      exp_valid = 1'b0;
      exp_instr = NOP_INSTR;
    end else if (!s) begin
      exp_pc   = last_issued;
      exp_next = 14'((int'(last_issued) + 1) % 16384);
      if (exp_q.size() > 0) begin
        exp_valid = 1'b1;
        exp_instr = exp_q.pop_front();
      end else begin
        exp_valid = 1'b0;
        exp_instr = NOP_INSTR;
      end
      exp_q.push_back(word(a));
      last_issued = a;
    end
  endtask

  task automatic check_id(input string tag);
    check({tag, ".valid"}, 32'(id_valid),   32'(exp_valid));
    check({tag, ".instr"}, 32'(id_instr),   32'(exp_instr));
    check({tag, ".pc"},    32'(id_pc),      32'(exp_pc));
    check({tag, ".next"},  32'(id_next_pc), 32'(exp_next));
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic f, input logic s, input logic [13:0] a);
    flush          = f;
    stall          = s;
    fetch_addr     = a;
    prog_mem_rdata = prev_rd ? word(prev_addr) : garbage;
    #1;
    check("rd_en", 32'(prog_mem_rd_en), 32'(!s));
    @(posedge clock);
    model_edge(f, s, a);
    prev_rd   = !s;
    prev_addr = a;
    #1;
    check_id("id");
    @(negedge clock);
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    flush = 1'b0; stall = 1'b0; fetch_addr = '0; prog_mem_rdata = garbage;
    model_reset();
    repeat (2) @(negedge clock);
    check_id("rst");
    nreset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [13:0] pc;
  logic        f, s;

  initial begin
    garbage = 16'hDEAD;
    nreset  = 1'b0;
    #1;
    check_id("rst_async");
    do_reset();

    // Bubble then 0,1,2 in order
    step(0, 0, 14'd0);
    check("bubble", 32'(id_valid), 32'd0);
    step(0, 0, 14'd1);
    check("first_instr", 32'(id_instr), 32'hA000);
    step(0, 0, 14'd2);
    check("second_pc", 32'(id_pc), 32'd1);

    // Three-cycle stall; later memory data is garbage and must never surface
    step(0, 1, 14'd3);
    step(0, 1, 14'd3);
    step(0, 1, 14'd3);
    check("stall_hold_pc", 32'(id_pc), 32'd1);
    step(0, 0, 14'd3);
    check("from_hold", 32'(id_instr), 32'hA002);
    step(0, 0, 14'd4);
    check("after_hold", 32'(id_instr), 32'hA003);

    // Flush with req_pc=5, redirect to 0x100
    step(0, 0, 14'd5);
    step(1, 0, 14'd6);
    check("flush_nop", 32'(id_instr), 32'(NOP_INSTR));
    step(0, 0, 14'h100);
    check("flush_bubble", 32'(id_valid), 32'd0);
    step(0, 0, 14'h101);
    check("redirect_pc", 32'(id_pc), 32'h100);

    // Flush together with stall while the hold buffer is full
    step(0, 1, 14'h102);
    step(1, 1, 14'h102);
    step(0, 0, 14'h200);
    step(0, 0, 14'h201);
    check("no_stale", 32'(id_pc), 32'h200);

    // PC wrap
    step(0, 0, 14'h3FFF);
    step(0, 0, 14'h0000);
    check("wrap_next", 32'(id_next_pc), 32'h0000);
    step(0, 0, 14'h0001);

    // Asynchronous reset in the middle of a stall with the buffer full
    step(0, 1, 14'h0002);
    nreset = 1'b0;
    #1;
    model_reset();
    check_id("rst_mid_stall");
    do_reset();
    step(0, 0, 14'd0);
    check("restart_bubble", 32'(id_valid), 32'd0);
    step(0, 0, 14'd1);
    check("restart_first", 32'(id_instr), 32'hA000);

    // Randomized traffic; fetch PC holds under stall and redirects on flush
    pc = 14'd2;
    for (int i = 0; i < 400; i++) begin
      garbage = 16'($urandom);
      f = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 3) == 0);
      step(f, s, pc);
      if (f) pc = ($urandom_range(0, 3) == 0) ? 14'h3FFD : 14'($urandom);
      else if (!s) pc = pc + 14'd1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
